// File: rtl/legv8_insn_encoder_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the LEGv8 instruction encoder.
// Opcode patterns match the single-cycle control decoder.
package legv8_enc_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    localparam int REG_W   = 5;
    localparam int IMM_W   = 26;
    localparam int IMM9_W  = 9;
    localparam int IMM12_W = 12;
    localparam int IMM16_W = 16;
    localparam int IMM19_W = 19;
    localparam int SHAMT_W = 6;

    // Bits selected by mask must be all-zero (unsigned fit).
    function automatic logic fits_unsigned(input logic [25:0] v, input logic [25:0] mask);
        return ((v & mask) == 26'd0);
    endfunction

    // Bits selected by mask must all equal the sign (two's complement fit).
    function automatic logic fits_signed(input logic [25:0] v, input logic [25:0] mask);
        return ((v & mask) == 26'd0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/legv8_insn_encoder_if.sv
`timescale 1ns/1ps
// Request and instruction-memory write bus of the LEGv8 encoder.
interface legv8_insn_encoder_if #(parameter int ADDR_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rn;
    logic [4:0]        req_rm;
    logic [25:0]       req_imm;
    logic [1:0]        req_hw;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/legv8_field_pack.sv
`timescale 1ns/1ps
// Combinational packer: op + fields -> 32-bit LEGv8 word, illegal/range flags.
// Range checking is compiled in with LEGV8_ENC_RANGECHK_EN.
module legv8_field_pack
    import legv8_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    // Field packing per instruction format.
    always_comb begin
        word      = 32'd0;
        illegal   = 1'b0;
        range_err = 1'b0;
        case (op)
            OP_AND:  word = {OPC_AND, rm, {SHAMT_W{1'b0}}, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, {SHAMT_W{1'b0}}, rn, rd};
            OP_ADD:  word = {OPC_ADD, rm, {SHAMT_W{1'b0}}, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, {SHAMT_W{1'b0}}, rn, rd};
            OP_ADDI: word = {OPC_ADDI, imm[IMM12_W-1:0], rn, rd};
            OP_SUBI: word = {OPC_SUBI, imm[IMM12_W-1:0], rn, rd};
            OP_LDUR: word = {OPC_LDUR, imm[IMM9_W-1:0], 2'b00, rn, rd};
            OP_STUR: word = {OPC_STUR, imm[IMM9_W-1:0], 2'b00, rn, rd};
            OP_B:    word = {OPC_B, imm[IMM_W-1:0]};
            OP_CBZ:  word = {OPC_CBZ, imm[IMM19_W-1:0], rd};
            OP_MOVZ: word = {OPC_MOVZ, hw, imm[IMM16_W-1:0], rd};
            default: illegal = 1'b1;
        endcase
`ifdef LEGV8_ENC_RANGECHK_EN
        case (op)
            OP_ADDI, OP_SUBI: range_err = !fits_unsigned(imm, 26'h3FFF000);
            OP_LDUR, OP_STUR: range_err = !fits_signed(imm, 26'h3FFFF00);
            OP_CBZ:           range_err = !fits_signed(imm, 26'h3FC0000);
            OP_MOVZ:          range_err = !fits_unsigned(imm, 26'h3FF0000);
            default:          range_err = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/legv8_insn_encoder.sv
`timescale 1ns/1ps
// LEGv8 instruction encoder: streams packed words to sequential imem addresses.
// Optional immediate range checking: define LEGV8_ENC_RANGECHK_EN.
module legv8_insn_encoder
    import legv8_enc_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic              finish,
    input  logic [ADDR_W-1:0] base_addr,
    legv8_insn_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    state_e            state_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [CNT_W-1:0]  count_r;
    logic              err_r;
    logic              done_r;

    logic [31:0]       word_s;
    logic              illegal_s;
    logic              range_err_s;
    logic              accept_s;
    logic              complete_s;
    logic              drop_s;

    legv8_field_pack u_pack (
        .op        (bus.req_op),
        .rd        (bus.req_rd),
        .rn        (bus.req_rn),
        .rm        (bus.req_rm),
        .imm       (bus.req_imm),
        .hw        (bus.req_hw),
        .word      (word_s),
        .illegal   (illegal_s),
        .range_err (range_err_s)
    );

    assign bus.req_ready = (state_r == ST_RUN) && (!we_r || bus.imem_ready);
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign complete_s    = we_r && bus.imem_ready;
    assign drop_s        = illegal_s || range_err_s;

    // Control FSM, output word register, address and counter.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'd0;
            count_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (complete_s) begin
                addr_r <= addr_r + ADDR_W'(4);
                if (count_r != {CNT_W{1'b1}}) begin
                    count_r <= count_r + CNT_W'(1);
                end
            end
            // A completing word and a new acceptance can share one edge.
            if (accept_s) begin
                if (drop_s) begin
                    err_r <= 1'b1;
                    if (complete_s) begin
                        we_r <= 1'b0;
                    end
                end else begin
                    we_r    <= 1'b1;
                    wdata_r <= word_s;
                end
            end else if (complete_s) begin
                we_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        addr_r  <= base_addr;
                        count_r <= {CNT_W{1'b0}};
                        err_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (finish) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!we_r || complete_s) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign busy           = (state_r != ST_IDLE);
    assign done           = done_r;
    assign count          = count_r;
    assign err            = err_r;

endmodule

// File: tb/tb_legv8_insn_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for legv8_insn_encoder: directed vectors, monitor checks writes.
module tb_legv8_insn_encoder;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        start;
    logic        finish;
    logic [63:0] base_addr;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        err;

    int          total = 0;
    int          bad = 0;
    exp_t        sb_q[$];
    logic [63:0] exp_addr;
    int          n_pushed = 0;

    legv8_insn_encoder_if #(.ADDR_W(64)) bus ();

    legv8_insn_encoder #(.ADDR_W(64), .CNT_W(16)) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .start     (start),
        .finish    (finish),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed write must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (resetl && bus.imem_we && bus.imem_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", bus.imem_wdata, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", bus.imem_addr, e.addr);
                check("wr_data", {32'd0, bus.imem_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                        input logic legal, input logic [31:0] word);
        bit got;
        got = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_rd = rd; bus.req_rn = rn; bus.req_rm = rm;
        bus.req_imm = imm; bus.req_hw = hw;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if (bus.req_ready) begin
                got = 1'b1;
                if (legal) begin
                    sb_q.push_back('{addr: exp_addr, data: word});
                    exp_addr = exp_addr + 64'd4;
                    n_pushed++;
                end
            end
            @(posedge CLK); #1;
        end
        bus.req_valid = 1'b0;
        if (!got) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_start(input logic [63:0] base);
        start = 1'b1; base_addr = base;
        tick(1);
        start = 1'b0;
        exp_addr = base;
        n_pushed = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {63'd0, bus.imem_we}, 64'd0);
        check({tag, "_addr"}, bus.imem_addr, 64'd0);
        check({tag, "_wdata"}, {32'd0, bus.imem_wdata}, 64'd0);
        check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_count"}, {48'd0, count}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        logic [63:0] pend_addr;
        int          done_cnt;
        logic        range_legal;
`ifdef LEGV8_ENC_RANGECHK_EN
        range_legal = 1'b0;
`else
        range_legal = 1'b1;
`endif
        resetl = 1'b0; start = 1'b0; finish = 1'b0; base_addr = 64'd0;
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_rd = 5'd0; bus.req_rn = 5'd0;
        bus.req_rm = 5'd0; bus.req_imm = 26'd0; bus.req_hw = 2'd0; bus.imem_ready = 1'b1;
        exp_addr = 64'd0;
        #12;
        check_reset_outputs("reset");
        tick(1);
        resetl = 1'b1;
        tick(1);

        do_start(64'h100);
        check("busy_run", {63'd0, busy}, 64'd1);
        send(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 32'h8B020023);
        tick(1);
        check("count_after_add", {48'd0, count}, 64'd1);
        send(4'd4, 5'd9, 5'd9, 5'd0, 26'd4095, 2'd0, 1'b1, 32'h913FFD29);
        send(4'd9, 5'd2, 5'd10, 5'd0, 26'h3FFFFF8, 2'd0, 1'b1, 32'hF85F8142);
        send(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b1, 32'h17FFFFFF);
        send(4'd8, 5'd5, 5'd0, 5'd0, 26'd2, 2'd0, 1'b1, 32'hB4000045);
        send(4'd6, 5'd1, 5'd0, 5'd0, 26'h000BEEF, 2'd1, 1'b1, 32'hD2B7DDE1);
        tick(1);

        // Stall with SUB pending for three cycles.
        bus.imem_ready = 1'b0;
        pend_addr = exp_addr;
        send(4'd3, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 1'b1, 32'hCB0600A4);
        for (int i = 0; i < 3; i++) begin
            check("stall_we", {63'd0, bus.imem_we}, 64'd1);
            check("stall_addr", bus.imem_addr, pend_addr);
            check("stall_wdata", {32'd0, bus.imem_wdata}, 64'hCB0600A4);
            check("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
            check("stall_count", {48'd0, count}, 64'(n_pushed - 1));
            tick(1);
        end
        bus.imem_ready = 1'b1;
        send(4'd1, 5'd7, 5'd8, 5'd9, 26'd0, 2'd0, 1'b1, 32'hAA090107);
        check("post_release_we", {63'd0, bus.imem_we}, 64'd1);
        check("post_release_wdata", {32'd0, bus.imem_wdata}, 64'hAA090107);
        send(4'd5, 5'd2, 5'd3, 5'd0, 26'd1, 2'd0, 1'b1, 32'hD1000462);
        send(4'd10, 5'd1, 5'd2, 5'd0, 26'd16, 2'd0, 1'b1, 32'hF8010041);
        tick(1);
        check("err_clean", {63'd0, err}, 64'd0);

        send(4'd4, 5'd0, 5'd0, 5'd0, 26'd4096, 2'd0, range_legal, 32'h91000000);
        tick(1);
        check("err_range", {63'd0, err}, {63'd0, !range_legal});
        send(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0, 32'd0);
        tick(1);
        check("err_illegal", {63'd0, err}, 64'd1);
        check("we_after_illegal", {63'd0, bus.imem_we}, 64'd0);

        // Finish with one word pending.
        bus.imem_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b1, 32'h8A030041);
        finish = 1'b1;
        tick(1);
        finish = 1'b0;
        tick(2);
        check("drain_busy", {63'd0, busy}, 64'd1);
        check("drain_we", {63'd0, bus.imem_we}, 64'd1);
        check("drain_req_ready", {63'd0, bus.req_ready}, 64'd0);
        bus.imem_ready = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        tick(1);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("final_count", {48'd0, count}, 64'(n_pushed));
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("err_sticky", {63'd0, err}, 64'd1);

        // Restart then reset during a stall.
        do_start(64'h2000);
        check("restart_err", {63'd0, err}, 64'd0);
        check("restart_count", {48'd0, count}, 64'd0);
        bus.imem_ready = 1'b0;
        send(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 32'h8B020023);
        tick(1);
        check("pre_reset_we", {63'd0, bus.imem_we}, 64'd1);
        #2;
        resetl = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("midreset");
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
